// File: rtl/ahb_sec_mem_sub_if.sv
// AHB5 bus bundle between a manager (or decoder/interconnect) and ahb_sec_mem_sub.
// hready is the bus-level HREADY returned by the interconnect.
interface ahb_sec_mem_sub_if;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hnonsec;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  modport master (
    output hsel, haddr, htrans, hwrite, hsize, hburst, hnonsec, hwdata, hready,
    input  hreadyout, hresp, hrdata
  );

  modport slave (
    input  hsel, haddr, htrans, hwrite, hsize, hburst, hnonsec, hwdata, hready,
    output hreadyout, hresp, hrdata
  );
endinterface

// File: rtl/ahb_sec_mem_sub.sv
// AHB5 subordinate backed by a word memory: HNONSEC window enforcement, programmable
// OKAY wait states and the two-cycle ERROR response with a saturating error counter.
module ahb_sec_mem_sub #(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] NS_BASE     = 32'h0000_0200,
  parameter logic [31:0] NS_LIMIT    = 32'h0000_03FF
) (
  input  logic             hclk,
  input  logic             hresetn,
  ahb_sec_mem_sub_if.slave bus,
  output logic [7:0]       err_count
);

  localparam int unsigned AW       = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [32:0] MemBytes = 33'(MEM_DEPTH) << 2;
  localparam logic [3:0]  WaitInit = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StErr1 = 2'd2;
  localparam logic [1:0] StErr2 = 2'd3;

  logic [1:0]    state_q, state_d;
  logic          valid_q, valid_d;
  logic          write_q, write_d;
  logic [AW-1:0] index_q, index_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [7:0]    err_count_q, err_count_d;

  logic [31:0] mem [MEM_DEPTH];

  logic accept;
  logic ns_err;
  logic addr_err;
  logic ready;
  logic complete;

  assign accept = bus.hsel & bus.hready & bus.htrans[1];

  // Non-secure accesses are confined to the window; secure ones see the whole memory.
  assign ns_err   = bus.hnonsec & ((bus.haddr < NS_BASE) | (bus.haddr > NS_LIMIT));
  assign addr_err = (bus.hsize != 3'b010) | (bus.haddr[1:0] != 2'b00) |
                    ({1'b0, bus.haddr} >= MemBytes) | ns_err;

  assign ready    = (state_q == StIdle) | (state_q == StErr2);
  assign complete = valid_q & ready;

  assign bus.hreadyout = ready;
  assign bus.hresp     = (state_q == StErr1) | (state_q == StErr2);
  assign bus.hrdata    = (complete & ~write_q) ? mem[index_q] : 32'h0;
  assign err_count     = err_count_q;

  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    write_d     = write_q;
    index_d     = index_q;
    cnt_d       = cnt_q;
    err_count_d = err_count_q;
    case (state_q)
      StWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StErr1: state_d = StErr2;
      default: begin
        // Ready states: the current data phase (if any) completes and a new
        // address phase may be accepted in the same cycle.
        state_d = StIdle;
        valid_d = 1'b0;
        if (accept) begin
          write_d = bus.hwrite;
          index_d = bus.haddr[AW+1:2];
          if (addr_err) begin
            state_d = StErr1;
            if (err_count_q != 8'hFF) begin
              err_count_d = err_count_q + 8'd1;
            end
          end else begin
            valid_d = 1'b1;
            if (WAIT_STATES > 0) begin
              state_d = StWait;
              cnt_d   = WaitInit;
            end
          end
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q     <= StIdle;
      valid_q     <= 1'b0;
      write_q     <= 1'b0;
      index_q     <= '0;
      cnt_q       <= 4'd0;
      err_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      write_q     <= write_d;
      index_q     <= index_d;
      cnt_q       <= cnt_d;
      err_count_q <= err_count_d;
    end
  end

  // Memory is not reset; a write held in its data phase is dropped by reset.
  always_ff @(posedge hclk) begin
    if (hresetn && complete && write_q) begin
      mem[index_q] <= bus.hwdata;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{bus.hburst, bus.htrans[0]};

endmodule

// File: tb/tb_ahb_sec_mem_sub.sv
// Directed bench for ahb_sec_mem_sub: a zero-wait and a two-wait instance share one
// stimulus bus; sel chooses which instance is selected and observed.
module tb_ahb_sec_mem_sub;

  logic hclk = 1'b0;
  always #5 hclk = ~hclk;

  logic        hresetn;
  logic        sel;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hnonsec;
  logic [31:0] hwdata;
  logic [7:0]  errc0, errc1;

  ahb_sec_mem_sub_if bus0 ();
  ahb_sec_mem_sub_if bus1 ();

  assign bus0.hsel    = hsel & ~sel;
  assign bus1.hsel    = hsel & sel;
  assign bus0.haddr   = haddr;
  assign bus1.haddr   = haddr;
  assign bus0.htrans  = htrans;
  assign bus1.htrans  = htrans;
  assign bus0.hwrite  = hwrite;
  assign bus1.hwrite  = hwrite;
  assign bus0.hsize   = hsize;
  assign bus1.hsize   = hsize;
  assign bus0.hburst  = hburst;
  assign bus1.hburst  = hburst;
  assign bus0.hnonsec = hnonsec;
  assign bus1.hnonsec = hnonsec;
  assign bus0.hwdata  = hwdata;
  assign bus1.hwdata  = hwdata;
  assign bus0.hready  = bus0.hreadyout;
  assign bus1.hready  = bus1.hreadyout;

  ahb_sec_mem_sub #(.WAIT_STATES(0)) u_dut0 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (bus0),
    .err_count (errc0)
  );

  ahb_sec_mem_sub #(.WAIT_STATES(2)) u_dut1 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .bus       (bus1),
    .err_count (errc1)
  );

  logic        o_ready, o_resp;
  logic [31:0] o_rdata;
  logic [7:0]  o_errc;
  assign o_ready = sel ? bus1.hreadyout : bus0.hreadyout;
  assign o_resp  = sel ? bus1.hresp     : bus0.hresp;
  assign o_rdata = sel ? bus1.hrdata    : bus0.hrdata;
  assign o_errc  = sel ? errc1          : errc0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Beat table for one pipelined sequence and its per-beat results.
  logic [31:0] s_addr [8];
  logic [31:0] s_wdata[8];
  logic        s_wr   [8];
  logic [2:0]  s_size [8];
  logic        s_ns   [8];
  logic [31:0] r_rdata[8];
  logic        r_resp0[8];
  logic        r_resp [8];
  int          r_waits[8];

  task automatic beat(input int i, input logic [31:0] addr, input logic wr,
                      input logic [31:0] wdata, input logic [2:0] size, input logic ns);
    s_addr[i]  = addr;
    s_wr[i]    = wr;
    s_wdata[i] = wdata;
    s_size[i]  = size;
    s_ns[i]    = ns;
  endtask

  // Issues beats 0..n-1 back to back, overlapping each address phase with the
  // previous data phase. Starts and ends 1 time unit after a rising edge.
  task automatic run_seq(input int n);
    int   issued, dp, done, cyc;
    logic rdy, fresh;
    issued = 0; dp = -1; done = 0; cyc = 0; fresh = 1'b0;
    for (int i = 0; i < n; i++) begin
      r_rdata[i] = 32'hDEAD_0000;
      r_resp0[i] = 1'bx;
      r_resp[i]  = 1'bx;
      r_waits[i] = -1;
    end
    while (done < n && cyc < 100) begin
      if (issued < n) begin
        hsel    = 1'b1;
        htrans  = (issued == 0) ? 2'b10 : 2'b11;
        haddr   = s_addr[issued];
        hwrite  = s_wr[issued];
        hsize   = s_size[issued];
        hnonsec = s_ns[issued];
        hburst  = (n > 1) ? 3'b011 : 3'b000;
      end else begin
        hsel   = 1'b0;
        htrans = 2'b00;
      end
      hwdata = (dp >= 0) ? s_wdata[dp] : 32'h0;
      #2;
      rdy = o_ready;
      if (dp >= 0) begin
        if (fresh) r_resp0[dp] = o_resp;
        fresh = 1'b0;
        if (rdy) begin
          r_rdata[dp] = o_rdata;
          r_resp[dp]  = o_resp;
          done++;
        end else begin
          r_waits[dp]++;
        end
      end
      @(posedge hclk);
      #1;
      cyc++;
      if (rdy) begin
        dp = (issued < n) ? issued : -1;
        if (issued < n) begin
          r_waits[issued] = 0;
          fresh = 1'b1;
          issued++;
        end
      end
    end
    check_eq("seq_done", 32'(done), 32'(n));
    hsel   = 1'b0;
    htrans = 2'b00;
    hwdata = 32'h0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b010; hburst = 3'b000; hnonsec = 1'b0; hwdata = 32'h0;
    hresetn = 1'b0;
    repeat (2) @(posedge hclk);
    #1;
    for (int k = 0; k < 2; k++) begin
      sel = k[0];
      #1;
      check_eq("rst_ready", 32'(o_ready), 32'd1);
      check_eq("rst_resp", 32'(o_resp), 32'd0);
      check_eq("rst_rdata", o_rdata, 32'h0);
      check_eq("rst_errc", 32'(o_errc), 32'd0);
    end
    sel = 1'b0;
    hresetn = 1'b1;

    // Secure write then read, zero wait
    beat(0, 32'h0, 1'b1, 32'hCAFE_BABE, 3'b010, 1'b0); run_seq(1);
    check_eq("t1_wr_resp", 32'(r_resp[0]), 32'd0);
    check_eq("t1_wr_waits", 32'(r_waits[0]), 32'd0);
    beat(0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("t1_rd_data", r_rdata[0], 32'hCAFE_BABE);
    check_eq("t1_rd_resp", 32'(r_resp[0]), 32'd0);
    check_eq("t1_rd_waits", 32'(r_waits[0]), 32'd0);

    // Non-secure write outside the window
    beat(0, 32'h4, 1'b1, 32'h1122_3344, 3'b010, 1'b0); run_seq(1);
    beat(0, 32'h4, 1'b1, 32'hDEAD_BEEF, 3'b010, 1'b1); run_seq(1);
    check_eq("t2_err_resp1", 32'(r_resp0[0]), 32'd1);
    check_eq("t2_err_waits", 32'(r_waits[0]), 32'd1);
    check_eq("t2_err_resp2", 32'(r_resp[0]), 32'd1);
    check_eq("t2_err_rdata", r_rdata[0], 32'h0);
    check_eq("t2_errc", 32'(o_errc), 32'd1);
    beat(0, 32'h4, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("t2_rd_kept", r_rdata[0], 32'h1122_3344);

    // INCR4 write then INCR4 read
    for (int i = 0; i < 4; i++) beat(i, 32'(4 * i), 1'b1, 32'(16 + i), 3'b010, 1'b0);
    run_seq(4);
    check_eq("t3_wr_waits", 32'(r_waits[0] + r_waits[1] + r_waits[2] + r_waits[3]), 32'd0);
    for (int i = 0; i < 4; i++) beat(i, 32'(4 * i), 1'b0, 32'h0, 3'b010, 1'b0);
    run_seq(4);
    for (int i = 0; i < 4; i++) check_eq("t3_rd_data", r_rdata[i], 32'(16 + i));
    check_eq("t3_rd_waits", 32'(r_waits[0] + r_waits[1] + r_waits[2] + r_waits[3]), 32'd0);

    // Non-secure window and illegal accesses
    beat(0, 32'h200, 1'b1, 32'hA5A5_A5A5, 3'b010, 1'b1); run_seq(1);
    check_eq("t4_ns_wr_resp", 32'(r_resp[0]), 32'd0);
    beat(0, 32'h200, 1'b0, 32'h0, 3'b010, 1'b1); run_seq(1);
    check_eq("t4_ns_rd_data", r_rdata[0], 32'hA5A5_A5A5);
    check_eq("t4_ns_rd_resp", 32'(r_resp[0]), 32'd0);
    beat(0, 32'h3FC, 1'b1, 32'h3C3C_3C3C, 3'b010, 1'b1); run_seq(1);
    check_eq("t4_ns_limit_resp", 32'(r_resp[0]), 32'd0);
    beat(0, 32'h202, 1'b0, 32'h0, 3'b010, 1'b1); run_seq(1);
    check_eq("t4_unaligned_resp", 32'(r_resp[0]), 32'd1);
    check_eq("t4_unaligned_errc", 32'(o_errc), 32'd2);
    beat(0, 32'h0, 1'b0, 32'h0, 3'b001, 1'b0); run_seq(1);
    check_eq("t4_hsize_resp", 32'(r_resp[0]), 32'd1);
    check_eq("t4_hsize_errc", 32'(o_errc), 32'd3);
    beat(0, 32'h400, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("t4_range_resp", 32'(r_resp[0]), 32'd1);
    beat(0, 32'h1FC, 1'b0, 32'h0, 3'b010, 1'b1); run_seq(1);
    check_eq("t4_ns_below_resp", 32'(r_resp[0]), 32'd1);
    check_eq("t4_ns_below_errc", 32'(o_errc), 32'd5);

    // A bad beat in the middle of a burst does not abort the rest
    beat(0, 32'h8, 1'b1, 32'h0000_0055, 3'b010, 1'b0);
    beat(1, 32'h6, 1'b0, 32'h0, 3'b010, 1'b0);
    beat(2, 32'h8, 1'b0, 32'h0, 3'b010, 1'b0);
    run_seq(3);
    check_eq("t4_mix_resp0", 32'(r_resp[0]), 32'd0);
    check_eq("t4_mix_resp1", 32'(r_resp[1]), 32'd1);
    check_eq("t4_mix_rdata1", r_rdata[1], 32'h0);
    check_eq("t4_mix_rdata2", r_rdata[2], 32'h0000_0055);
    check_eq("t4_mix_errc", 32'(o_errc), 32'd6);

    // Error counter saturates at 255
    for (int i = 0; i < 250; i++) begin
      beat(0, 32'h2, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    end
    check_eq("errc_255", 32'(o_errc), 32'd255);
    beat(0, 32'h2, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("errc_sat", 32'(o_errc), 32'd255);

    // Two wait states
    sel = 1'b1;
    beat(0, 32'h0, 1'b1, 32'h0000_0077, 3'b010, 1'b0); run_seq(1);
    check_eq("t5_wr_waits", 32'(r_waits[0]), 32'd2);
    check_eq("t5_wr_resp", 32'(r_resp[0]), 32'd0);
    beat(0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("t5_rd_waits", 32'(r_waits[0]), 32'd2);
    check_eq("t5_rd_data", r_rdata[0], 32'h0000_0077);
    beat(0, 32'h8, 1'b1, 32'h1234_5678, 3'b010, 1'b0);
    beat(1, 32'h8, 1'b0, 32'h0, 3'b010, 1'b0);
    run_seq(2);
    check_eq("t5_b2b_waits0", 32'(r_waits[0]), 32'd2);
    check_eq("t5_b2b_waits1", 32'(r_waits[1]), 32'd2);
    check_eq("t5_b2b_data", r_rdata[1], 32'h1234_5678);
    beat(0, 32'h0, 1'b0, 32'h0, 3'b010, 1'b1); run_seq(1);
    check_eq("t5_err_waits", 32'(r_waits[0]), 32'd1);
    check_eq("t5_err_resp", 32'(r_resp[0]), 32'd1);
    check_eq("t5_errc", 32'(o_errc), 32'd1);

    // Reset during a write wait state
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h8; hsize = 3'b010;
    hnonsec = 1'b0; hburst = 3'b000;
    @(posedge hclk);
    #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h0000_0099; hresetn = 1'b0;
    #2;
    check_eq("t6_wait_low", 32'(o_ready), 32'd0);
    @(posedge hclk);
    #1;
    check_eq("t6_ready", 32'(o_ready), 32'd1);
    check_eq("t6_resp", 32'(o_resp), 32'd0);
    check_eq("t6_errc", 32'(o_errc), 32'd0);
    check_eq("t6_rdata", o_rdata, 32'h0);
    hresetn = 1'b1;
    hwdata = 32'h0;
    beat(0, 32'h8, 1'b0, 32'h0, 3'b010, 1'b0); run_seq(1);
    check_eq("t6_word_kept", r_rdata[0], 32'h1234_5678);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahb_sec_mem_sub.md
Name: ahb_sec_mem_sub

Overview:
AHB5 subordinate (responder) that sits at the far end of the command-driven AHB manager inside ahb_top. It services single and burst transfers from a word-organised on-chip memory and enforces TrustZone-style security using HNONSEC. It returns the two-cycle ERROR response for illegal accesses and inserts a configurable number of wait states.

Parameters:
MEM_DEPTH, 256, number of 32-bit words (byte span = 4*MEM_DEPTH)
WAIT_STATES, 0, wait cycles inserted in every OKAY data phase (0..15)
NS_BASE, 32'h0000_0200, first byte address of the non-secure window
NS_LIMIT, 32'h0000_03FF, last byte address of the non-secure window (inclusive)

Ports:
hclk  in  1  bus clock, all logic on rising edge
hresetn  in  1  synchronous active-low reset, sampled on rising hclk
hsel  in  1  subordinate select from decoder
haddr  in  32  byte address (address phase)
htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
hwrite  in  1  1 write, 0 read
hsize  in  3  transfer size; only 3'b010 (word) legal
hburst  in  3  burst type; accepted, not checked
hnonsec  in  1  1 non-secure access
hwdata  in  32  write data (data phase)
hready  in  1  bus-level HREADY (transfer-complete of previous data phase)
hreadyout  out  1  this subordinate's ready
hresp  out  1  0 OKAY, 1 ERROR
hrdata  out  32  read data
err_count  out  8  saturating count of ERROR responses issued

Behaviour:
- Reset (hresetn=0 at a rising edge): state IDLE, hreadyout=1, hresp=0, hrdata=0, err_count=0, captured address-phase registers cleared. Memory contents are not reset. Reset mid-transfer abandons the pending data phase; a pending write is not committed.
- Transfer accept: on a rising edge with hsel=1, hready=1 and htrans[1]=1 (NONSEQ/SEQ), latch hwrite, word index haddr[31:2] and the error flag. IDLE/BUSY, or hsel=0, produce a zero-wait OKAY (no state change beyond IDLE).
- Error flag set if any of: hsize!=3'b010; haddr[1:0]!=0; haddr>=4*MEM_DEPTH; hnonsec=1 and haddr outside [NS_BASE,NS_LIMIT]. Secure accesses (hnonsec=0) may reach the whole memory.
- FSM states: IDLE, WAIT, ERR1, ERR2.
  - IDLE: hreadyout=1, hresp=0. On accept: error -> ERR1; else WAIT_STATES>0 -> WAIT (counter=WAIT_STATES-1); else stay in the data phase with hreadyout=1 this next cycle (DATA implied by the valid flag).
  - WAIT: hreadyout=0, hresp=0; counter decrements each cycle; at 0, the next cycle is the final data cycle (hreadyout=1).
  - ERR1: hreadyout=0, hresp=1, one cycle -> ERR2. err_count increments on entry, saturating at 255.
  - ERR2: hreadyout=1, hresp=1, one cycle. A new accept in this cycle is handled normally, as is a manager cancel to IDLE.
- Data phase completion = the cycle with hreadyout=1 and the valid flag set. Write: mem[index] <= hwdata at the end of that cycle. Read: hrdata = mem[index] during that cycle; hrdata=0 otherwise. Error transfers never modify memory and drive hrdata=0.
- Pipelining: the next address phase may overlap the current data phase. Acceptance is evaluated only when hready=1. Write-then-read to the same address back to back returns the new data (the write commits before the read's data phase).
- Bursts: each beat uses its own haddr. SEQ is treated as NONSEQ. A per-beat error does not abort later beats.

Test Plan:
1. Secure (hnonsec=0) write 0xCAFEBABE to 0x0, then read 0x0 -> hrdata=0xCAFEBABE, hresp=0, zero wait.
2. hnonsec=1 write 0xDEADBEEF to 0x4 -> hreadyout 0 then 1 with hresp=1 both cycles; secure read of 0x4 returns prior value; err_count=1.
3. INCR4 write 0x10..0x13 to 0x0/0x4/0x8/0xC back to back, then INCR4 read -> 0x10,0x11,0x12,0x13, four consecutive ready cycles.
4. hnonsec=1 write/read 0xA5A5A5A5 at 0x200 -> OKAY with matching data. Unaligned 0x202 or hsize=3'b001 -> ERROR, err_count increments.
5. WAIT_STATES=2: read 0x0 -> hreadyout low exactly 2 cycles, then high with correct data. Back-to-back write 0x8 / read 0x8 returns the written word.
6. Assert hresetn=0 during a WAIT cycle of a write -> next cycle hreadyout=1, hresp=0, err_count=0, target word unchanged.
